// File: rtl/noc_pkg.sv
// noc_pkg: flit layout, field positions and helpers shared by the NoC injection path.
package noc_pkg;
    localparam int FLIT_W    = 20;
    localparam int SRC_HI    = 19;
    localparam int SRC_LO    = 12;
    localparam int DST_HI    = 7;
    localparam int DST_LO    = 4;
    localparam int CHK_HI    = 3;
    localparam int CHK_LO    = 0;
    localparam int CLUSTER_W = 2;
    localparam int LOCAL_W   = 2;

    typedef struct packed {
        logic [SRC_HI-SRC_LO:0] src;
        logic [3:0]             rsv;
        logic [CLUSTER_W-1:0]   cluster;
        logic [LOCAL_W-1:0]     lcl;
        logic [CHK_HI-CHK_LO:0] chk;
    } flit_t;

    typedef enum logic [1:0] {IDLE, HOLD, FULL} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/nic_inject_fifo.sv
// nic_inject_fifo: first-word-fall-through flit FIFO with registered IDLE/HOLD/FULL flags.
module nic_inject_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  flit_t       wr_data,
    input  logic        wr_en,
    input  logic        rd_en,
    output flit_t       rd_data,
    output logic        rd_valid,
    output logic        drop,
    output logic [AW:0] count,
    output logic        full,
    output logic        empty
);
    flit_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_nxt;
    logic          pop, write;
    state_t        state;

    assign pop       = rd_en && !empty;
    assign write     = wr_en && (!full || pop);
    assign drop      = wr_en && full && !pop;
    assign count_nxt = (write && !pop) ? count + 1'b1 : (!write && pop) ? count - 1'b1 : count;
    assign full      = state == FULL;
    assign empty     = state == IDLE;
    assign rd_valid  = !empty;
    // Masked while empty so stale storage never leaks onto the router port.
    assign rd_data   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk)
        if (write) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
        end else begin
            if (write) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            state <= (count_nxt == '0) ? IDLE : (count_nxt == (AW+1)'(DEPTH)) ? FULL : HOLD;
        end
    end
endmodule

// File: rtl/nic_inject_queue.sv
// nic_inject_queue: NoC local-port injection queue with drop/error counters.
// Define NIC_INJ_CHECK_EN to reject malformed or self-addressed flits.
module nic_inject_queue
    import noc_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int NODE_ID = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLUSTER_W-1:0]     out_dest_cluster,
    output logic [LOCAL_W-1:0]       out_dest_local,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [7:0]               drop_cnt,
    output logic [7:0]               err_cnt
);
    flit_t in_flit, out_flit;
    logic  push, drop;

    assign in_flit          = in_data;
    assign out_data         = out_flit;
    assign out_dest_cluster = out_flit.cluster;
    assign out_dest_local   = out_flit.lcl;

`ifdef NIC_INJ_CHECK_EN
    logic bad;
    assign bad  = in_flit.src != 8'(NODE_ID) || in_flit.rsv != '0 ||
                  in_flit.chk != {in_flit.cluster, in_flit.lcl} ||
                  {in_flit.cluster, in_flit.lcl} == 4'(NODE_ID);
    assign push = in_valid && !bad;

    always_ff @(posedge clk or posedge rst)
        if (rst) err_cnt <= '0;
        else if (in_valid && bad) err_cnt <= sat_inc8(err_cnt);
`else
    assign push    = in_valid;
    assign err_cnt = 8'(NODE_ID) & 8'h00;
`endif

    nic_inject_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (in_flit),
        .wr_en   (push),
        .rd_en   (out_ready),
        .rd_data (out_flit),
        .rd_valid(out_valid),
        .drop    (drop),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) drop_cnt <= '0;
        else if (drop) drop_cnt <= sat_inc8(drop_cnt);
endmodule

// File: doc/nic_inject_queue.md
# nic_inject_queue

Local-port injection queue for one NoC node. It captures the 20-bit flit stream from the node's traffic ROM (`dataout`/`out_valid`), which cannot be stalled. Flits are buffered in a FIFO and presented to the router's local input port with a valid/ready handshake. The destination field is pre-decoded into cluster/local indices, and a flit that arrives while the queue is full is dropped and counted.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `NODE_ID`, 0: this node's ID (0..15); used by the source checks.

Ports (reset is asynchronous, active-high):
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `in_data`, input, 20: flit from the traffic ROM.
- `in_valid`, input, 1: `in_data` is valid this cycle; there is no backpressure path to the source.
- `out_data`, output, 20: head flit.
- `out_valid`, output, 1: head flit present.
- `out_ready`, input, 1: router accepts the head flit.
- `out_dest_cluster`, output, 2: `out_data[7:6]`.
- `out_dest_local`, output, 2: `out_data[5:4]`.
- `count`, output, $clog2(DEPTH)+1: occupancy.
- `full`, output, 1: high when `count == DEPTH`.
- `empty`, output, 1: high when `count == 0`.
- `drop_cnt`, output, 8: saturating count of overflow drops.
- `err_cnt`, output, 8: saturating count of check failures.

## Operation
Flit format:
- [19:12]: source ID (0..15).
- [11:8]: reserved, must be 0.
- [7:4]: destination ID, where dest[3:2] is the cluster and dest[1:0] is the local index.
- [3:0]: check nibble, which must equal [7:4].

Push and pop:
- Push occurs when `in_valid` is high and the flit passes the checks (see Configuration).
- Pop occurs when `out_valid && out_ready`.
- FIFO is first-word-fall-through. `out_data` is read combinationally from `mem[rd_ptr]`, and `out_valid = !empty`.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `count` is maintained as a separate register.

Boundary behaviour:
- Push while full without a same-cycle pop: the flit is dropped, `drop_cnt` increments, and the FIFO is unchanged.
- Push while full with a same-cycle pop: the push is accepted and `count` stays at DEPTH.
- Push and pop while non-empty: both take effect and `count` is unchanged.
- Push while empty: no bypass. The flit appears on `out_valid` the cycle after the write edge.
- Pop with `out_valid` low is ignored.
- Both counters saturate at 255 and never wrap.
- Outputs are not gated by the state of the traffic source. Bursts of any length, including 30 back-to-back flits, are absorbed up to DEPTH. The remaining flits drop unless the router drains concurrently.

Control states:
- IDLE (empty).
- HOLD (0 < count < DEPTH).
- FULL.
- Transitions follow `count` after each edge. The state is used only to derive `full`/`empty` as registered flags.

## Timing
Reset:
- `rst` high asynchronously clears the pointers and `count`, and zeroes both counters.
- Reset values: `full` 0, `empty` 1, `out_valid` 0.
- `out_data` and the dest fields are don't-care, but the bench expects 0 because the memory output is masked while empty.

Latency and handshake:
- Input to `out_valid` latency is 1 cycle: a write at edge N makes `out_valid` high during cycle N+1.
- `out_data` stays stable while `out_valid && !out_ready`.
- A flit is consumed on the edge where `out_valid && out_ready`; the next entry is visible in the following cycle.

Reset mid-stream:
- All buffered flits are discarded.
- There is no partial output: `out_valid` falls in the same cycle that `rst` rises.

## Configuration
- `NIC_INJ_CHECK_EN` defined:
  - A flit is rejected if any of these hold: `[19:12] != NODE_ID`, `[11:8] != 0`, `[3:0] != [7:4]`, or dest == NODE_ID (self-addressed).
  - A rejected flit is not enqueued and increments `err_cnt`.
  - A check failure takes precedence over overflow: `drop_cnt` is not incremented for a rejected flit.
- `NIC_INJ_CHECK_EN` undefined:
  - Every valid flit is a push candidate.
  - `err_cnt` is tied to 0.

## Structure
- Shared package `noc_pkg` holds:
  - `FLIT_W = 20` and the field-position constants (SRC_HI/LO, DST_HI/LO, CHK_HI/LO).
  - A `flit_t` packed struct.
  - `CLUSTER_W = 2`, `LOCAL_W = 2`.
  - A `sat_inc8` function.
- One sub-module, `nic_inject_fifo`: the storage, pointers, count and flags. The top level adds the check logic and the counters.

## Test plan
- Reset, then one flit 0x0B0FF with NODE_ID=11 → `out_valid` rises 1 cycle after the write; `out_dest_cluster = 3`, `out_dest_local = 3`; popped with `out_ready=1`; `empty = 1`.
- 15 back-to-back flits with `out_ready=0` and DEPTH=16 → `count = 15`, `full = 0`, `drop_cnt = 0`. Then 30 flits → `count = 16`, `drop_cnt = 29`. Draining returns the 16 stored flits in push order, first 0x0B0FF.
- Full FIFO with `out_ready=1` and a push in the same cycle → `count` stays 16 and `drop_cnt` is unchanged.
- With `NIC_INJ_CHECK_EN` and NODE_ID=11: push 0x0A0FF, 0x0B0FE, 0x0B0BB → `err_cnt = 3`, `empty` stays 1. Without the macro, `count = 3`.
- Assert `rst` with `count = 5` while popping → `out_valid` low immediately; after release, `empty = 1`, `count = 0`, both counters 0.
- Hold `out_ready=0` for 10 cycles with the head flit present → `out_data` is constant throughout; 300 overflow pushes saturate `drop_cnt` at 255.
